// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single memory port between instruction fetch (IF) and data
// memory (DM). It owns the 2:1 address/write-data steering (sel=0 routes IF,
// sel=1 routes DM) and grants one requester at a time until the memory acks.
// DM has fixed priority, with a starvation guard for IF and a watchdog on the
// memory ack.
//
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   if_req/if_addr        IF request (held until if_ack) and address
//   if_ack                one-cycle IF completion pulse (mirrors mem_ack)
//   dm_req/dm_we/dm_addr/dm_wdata  DM request, held until dm_ack
//   dm_ack                one-cycle DM completion pulse (mirrors mem_ack)
//   mem_req/mem_we/mem_addr/mem_wdata  steered memory request
//   mem_ack               memory completion, one cycle
//   sel                   current owner: 0=IF, 1=DM
//   timeout_err           sticky watchdog abort flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned max        = 31,
    parameter int unsigned STARVE_LIM = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           if_req,
    input  logic [max:0]   if_addr,
    output logic           if_ack,
    input  logic           dm_req,
    input  logic           dm_we,
    input  logic [max:0]   dm_addr,
    input  logic [max:0]   dm_wdata,
    output logic           dm_ack,
    output logic           mem_req,
    output logic           mem_we,
    output logic [max:0]   mem_addr,
    output logic [max:0]   mem_wdata,
    input  logic           mem_ack,
    output logic           sel,
    output logic           timeout_err
);

    localparam int unsigned SW = 4;  // holds STARVE_LIM up to 15
    localparam int unsigned WW = 8;  // holds TIMEOUT up to 255

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    state_e          state_q;
    logic            sel_q;
    logic [SW-1:0]   starve_q;
    logic [WW-1:0]   wd_q;
    logic            timeout_err_q;

    logic            starve_hit;
    logic            busy;

    // IF has waited through the maximum number of back-to-back DM grants
    assign starve_hit = if_req && (starve_q == SW'(STARVE_LIM));
    assign busy       = (state_q != IDLE);

    // Arbitration FSM, starvation counter and watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            starve_q      <= '0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dm_req && !starve_hit) begin
                        state_q <= BUSY_DM;
                        sel_q   <= 1'b1;
                        wd_q    <= '0;
                        // Only a waiting IF counts toward starvation; saturate
                        if (if_req && (starve_q != SW'(STARVE_LIM))) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end else if (if_req) begin
                        state_q  <= BUSY_IF;
                        sel_q    <= 1'b0;
                        wd_q     <= '0;
                        starve_q <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // An ack on the watchdog's last cycle still wins
                    if (mem_ack) begin
                        state_q <= IDLE;
                    end else if (wd_q == WW'(TIMEOUT)) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Port steering follows the registered owner
    assign mem_req     = busy;
    assign mem_we      = sel_q & dm_we;
    assign mem_addr    = sel_q ? dm_addr : if_addr;
    assign mem_wdata   = sel_q ? dm_wdata : '0;

    // Completion pulses pass mem_ack straight through to the current owner
    assign if_ack      = (state_q == BUSY_IF) && mem_ack;
    assign dm_ack      = (state_q == BUSY_DM) && mem_ack;

    assign sel         = sel_q;
    assign timeout_err = timeout_err_q;

endmodule
